// File: rtl/oport_uart_tx.sv
// Serialises every change of the processor output port OPORT as an 8N1 UART frame via a 4-entry queue.
// Optional build macro OPORT_TX_PARITY_EN inserts an even-parity bit between the data bits and STOP.
module oport_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] OPORT,
  output logic       txd,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef OPORT_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;
`endif

  state_e           state_q,  state_d;
  logic [7:0]       baud_q,   baud_d;
  logic [2:0]       bit_q,    bit_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       prev_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             txd_q,    txd_d;
  logic             busy_q,   busy_d;
  logic             ovf_q,    ovf_d;
`ifdef OPORT_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [7:0] head;
  logic       change;
  logic       bit_done;
  logic       pop;
  logic       push_ok;

  assign head     = fifo_mem[rd_ptr_q];
  assign change   = (OPORT != prev_q);
  assign bit_done = (baud_q == 8'd0);

  // A full queue still accepts a push when the transmitter pops on the same edge.
  assign push_ok  = change && ((count_q != CNT_FULL) || pop);

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef OPORT_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if ((state_q != S_IDLE) && !bit_done) begin
      baud_d = baud_q - 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        pop = (count_q != '0);
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd7) begin
`ifdef OPORT_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef OPORT_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          baud_d  = BAUD_LAST;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          // Chain straight into the next frame when bytes are waiting.
          pop     = (count_q != '0);
          state_d = S_IDLE;
          baud_d  = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 8'd0;
      end
    endcase

    if (pop) begin
      state_d  = S_START;
      baud_d   = BAUD_LAST;
      shift_d  = head;
`ifdef OPORT_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    ovf_d    = ovf_q | (change && !push_ok);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Outputs are derived from next-state values so the registered copies line up with the state.
  always_comb begin
    unique case (state_d)
      S_START:    txd_d = 1'b0;
      S_DATA:     txd_d = shift_d[0];
`ifdef OPORT_TX_PARITY_EN
      S_PARITY:   txd_d = parity_d;
`endif
      default:    txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_q   <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      prev_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef OPORT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      prev_q   <= OPORT;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
`ifdef OPORT_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // NOTE: queue storage is not reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      fifo_mem[wr_ptr_q] <= OPORT;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_oport_uart_tx.sv
// Directed bench for oport_uart_tx: single frames, back-to-back, overflow, reset mid-frame, reset release.
// Frame length follows OPORT_TX_PARITY_EN when defined for the build.
module tb_oport_uart_tx;

  localparam int CPB = 4;
`ifdef OPORT_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] OPORT;
  logic       txd;
  logic       busy;
  logic       overflow;

  int cmp_cnt = 0;
  int err_cnt = 0;

  oport_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .OPORT    (OPORT),
    .txd      (txd),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    check({tag, "_txd"}, 8'(txd), 8'd1);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_ovf"}, 8'(overflow), 8'(exp_ovf));
  endtask

  // Expected line level for cycle c (0 = first START cycle) of the frame carrying byte b.
  task automatic frame_cycle(input logic [7:0] b, input int c);
    int   idx;
    logic exp_bit;
    idx = c / CPB;
    if (idx == 0)                   exp_bit = 1'b0;
    else if (idx <= 8)              exp_bit = b[idx-1];
    else if (PAR_EN && (idx == 9))  exp_bit = ^b;
    else                            exp_bit = 1'b1;
    check($sformatf("frame_%h_c%0d_txd", b, c), 8'(txd), 8'(exp_bit));
    check($sformatf("frame_%h_c%0d_busy", b, c), 8'(busy), 8'd1);
  endtask

  task automatic expect_frame(input logic [7:0] b);
    for (int c = 0; c < FRAME_CYC; c++) begin
      frame_cycle(b, c);
      tick();
    end
  endtask

  initial begin
    rst   = 1'b0;
    OPORT = 8'h00;
    repeat (3) tick();
    check_idle("reset", 1'b0);

    // Quiet port: nothing is ever sent.
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle($sformatf("quiet_%0d", i), 1'b0);
    end

    // Single frame A5: enqueued at the first edge, START visible after the second.
    OPORT = 8'hA5;
    tick();
    check("a5_enq_txd", 8'(txd), 8'd1);
    check("a5_enq_busy", 8'(busy), 8'd1);
    tick();
    expect_frame(8'hA5);
    check_idle("a5_done", 1'b0);

    OPORT = 8'h07;
    tick();
    tick();
    expect_frame(8'h07);
    check_idle("x07_done", 1'b0);

    // Back-to-back: three changes on consecutive cycles, frames with no idle gap.
    OPORT = 8'h11;
    tick();
    OPORT = 8'h22;
    tick();
    OPORT = 8'h33;
    expect_frame(8'h11);
    expect_frame(8'h22);
    expect_frame(8'h33);
    check_idle("b2b_done", 1'b0);

    // Overflow: six changes during a frame; four are queued, two dropped.
    OPORT = 8'h40;
    tick();
    tick();
    for (int v = 0; v < 6; v++) begin
      OPORT = 8'h41 + 8'(v);
      frame_cycle(8'h40, v);
      tick();
    end
    for (int c = 6; c < FRAME_CYC; c++) begin
      frame_cycle(8'h40, c);
      tick();
    end
    check("ovf_set", 8'(overflow), 8'd1);
    expect_frame(8'h41);
    expect_frame(8'h42);
    expect_frame(8'h43);
    expect_frame(8'h44);
    check_idle("ovf_done", 1'b1);

    // Reset during DATA of 3C with a further byte queued behind it.
    OPORT = 8'h3C;
    tick();
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c == 1) OPORT = 8'h5A;
      frame_cycle(8'h3C, c);
      tick();
    end
    frame_cycle(8'h3C, 6);
    rst   = 1'b0;
    OPORT = 8'h00;
    tick();
    check_idle("midrst", 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check_idle($sformatf("post_rst_%0d", i), 1'b0);
    end

    // Releasing reset with a nonzero port counts as a change against 00.
    rst   = 1'b0;
    OPORT = 8'h81;
    tick();
    check_idle("rel_rst", 1'b0);
    rst = 1'b1;
    tick();
    check("rel_enq_txd", 8'(txd), 8'd1);
    check("rel_enq_busy", 8'(busy), 8'd1);
    tick();
    expect_frame(8'h81);
    check_idle("rel_done", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
